flag_rename_entry_gen: RTL

- Generalised flag rename entry; one instance per physical flag register in the scheduling stage.
- Parametrised in:
  - rename name width, commit-tag width and flag width;
  - number of register (dispatch) ports and number of CDB channels;
  - commit-vector offset.
- Tracks the entry lifecycle: free-list request, allocation, flag capture from the CDB, retirement on commit.
- Adds behaviour the previous generation lacks: explicit RELEASE state, lifecycle/tag visibility, release pulse, and a defined priority among any number of channels.

---
 rtl/flag_rename_entry_gen_pkg.sv | 16 +
 rtl/flag_rename_entry_gen_if.sv | 44 ++++
 rtl/flag_rename_chsel.sv | 28 ++
 rtl/flag_rename_entry_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/flag_rename_entry_gen_pkg.sv
// Shared definitions for the flag rename entry.
// Holds the lifecycle state encodings and the state-field width used by
// the entry, its interface and anything that observes oINFO_STATE.
package flag_rename_entry_gen_pkg;

    localparam int FLAGREN_STATE_W = 3;

    typedef enum logic [FLAGREN_STATE_W-1:0] {
        FLAGREN_ST_FREE_WAIT   = 3'd0,
        FLAGREN_ST_REG_WAIT    = 3'd1,
        FLAGREN_ST_FLAG_WAIT   = 3'd2,
        FLAGREN_ST_COMMIT_WAIT = 3'd3,
        FLAGREN_ST_RELEASE     = 3'd4
    } flagren_state_e;

endpackage

// File: rtl/flag_rename_entry_gen_if.sv
// Bus bundle between the scheduling stage and one flag rename entry.
// master: scheduler side, drives flush/commit/dispatch/CDB/free-list inputs.
// slave : the entry, drives the oINFO_* observation outputs.
interface flag_rename_entry_gen_if
    import flag_rename_entry_gen_pkg::*;
#(
    parameter int NAME_W = 4,
    parameter int TAG_W  = 6,
    parameter int FLAG_W = 5,
    parameter int REG_CH = 2,
    parameter int CDB_CH = 2
);
    logic                        iREMOVE_VALID;
    logic [2**TAG_W-1:0]         iCOMMIT_VECTOR;
    logic [REG_CH-1:0]           iREGIST_VALID;
    logic [REG_CH*NAME_W-1:0]    iREGIST_REGNAME;
    logic [REG_CH*TAG_W-1:0]     iREGIST_COMMIT_TAG;
    logic [CDB_CH-1:0]           iCDB_VALID;
    logic [CDB_CH*TAG_W-1:0]     iCDB_COMMIT_TAG;
    logic [CDB_CH*FLAG_W-1:0]    iCDB_FLAGS;
    logic                        iFREELIST_REGIST_VALID;
    logic                        oINFO_FREELIST_REQ;
    logic                        oINFO_FLAGS_VALID;
    logic [FLAG_W-1:0]           oINFO_FLAGS;
    logic [TAG_W-1:0]            oINFO_COMMIT_TAG;
    logic [FLAGREN_STATE_W-1:0]  oINFO_STATE;
    logic                        oINFO_RELEASE;

    modport master (
        output iREMOVE_VALID, iCOMMIT_VECTOR, iREGIST_VALID, iREGIST_REGNAME,
               iREGIST_COMMIT_TAG, iCDB_VALID, iCDB_COMMIT_TAG, iCDB_FLAGS,
               iFREELIST_REGIST_VALID,
        input  oINFO_FREELIST_REQ, oINFO_FLAGS_VALID, oINFO_FLAGS,
               oINFO_COMMIT_TAG, oINFO_STATE, oINFO_RELEASE
    );

    modport slave (
        input  iREMOVE_VALID, iCOMMIT_VECTOR, iREGIST_VALID, iREGIST_REGNAME,
               iREGIST_COMMIT_TAG, iCDB_VALID, iCDB_COMMIT_TAG, iCDB_FLAGS,
               iFREELIST_REGIST_VALID,
        output oINFO_FREELIST_REQ, oINFO_FLAGS_VALID, oINFO_FLAGS,
               oINFO_COMMIT_TAG, oINFO_STATE, oINFO_RELEASE
    );
endinterface

// File: rtl/flag_rename_chsel.sv
// Lowest-index-first match/select over N channels.
// Ports: valid[N], keys (N packed keys), key (compare value),
//        data (N packed words) -> hit (any channel matched),
//        sel (data of the lowest matching channel, 0 when no hit).
module flag_rename_chsel #(
    parameter int N      = 2,
    parameter int KEY_W  = 4,
    parameter int DATA_W = 6
) (
    input  logic [N-1:0]        valid,
    input  logic [N*KEY_W-1:0]  keys,
    input  logic [KEY_W-1:0]    key,
    input  logic [N*DATA_W-1:0] data,
    output logic                hit,
    output logic [DATA_W-1:0]   sel
);
    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i] && (keys[i*KEY_W +: KEY_W] == key)) begin
                hit = 1'b1;
                sel = data[i*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/flag_rename_entry_gen.sv
// One flag rename entry: tracks a physical flag register through
// free-list request, allocation, CDB flag capture and commit retirement.
// Ports: iCLOCK, inRESET (async, active-low), bus (slave modport) carrying
//        flush, commit vector, register ports, CDB channels, free-list
//        accept and the oINFO_* state/tag/flags/release observation outputs.
module flag_rename_entry_gen
    import flag_rename_entry_gen_pkg::*;
#(
    parameter int ENTRY_ID      = 0,
    parameter int NAME_W        = 4,
    parameter int TAG_W         = 6,
    parameter int FLAG_W        = 5,
    parameter int REG_CH        = 2,
    parameter int CDB_CH        = 2,
    parameter int COMMIT_OFFSET = 1
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    flag_rename_entry_gen_if.slave  bus
);
    flagren_state_e    state, state_nxt;
    logic              req, req_nxt;
    logic              flags_valid, flags_valid_nxt;
    logic [FLAG_W-1:0] flags, flags_nxt;
    logic [TAG_W-1:0]  tag, tag_nxt;

    logic              reg_hit;
    logic [TAG_W-1:0]  reg_tag;
    logic              cdb_hit;
    logic [FLAG_W-1:0] cdb_flags;
    logic [TAG_W-1:0]  commit_idx;
    logic              commit_hit;

    flag_rename_chsel #(.N(REG_CH), .KEY_W(NAME_W), .DATA_W(TAG_W)) u_reg_sel (
        .valid (bus.iREGIST_VALID),
        .keys  (bus.iREGIST_REGNAME),
        .key   (NAME_W'(ENTRY_ID)),
        .data  (bus.iREGIST_COMMIT_TAG),
        .hit   (reg_hit),
        .sel   (reg_tag)
    );

    flag_rename_chsel #(.N(CDB_CH), .KEY_W(TAG_W), .DATA_W(FLAG_W)) u_cdb_sel (
        .valid (bus.iCDB_VALID),
        .keys  (bus.iCDB_COMMIT_TAG),
        .key   (tag),
        .data  (bus.iCDB_FLAGS),
        .hit   (cdb_hit),
        .sel   (cdb_flags)
    );

    // Truncation to TAG_W bits makes the offset wrap around the vector.
    assign commit_idx = tag + TAG_W'(COMMIT_OFFSET);
    assign commit_hit = bus.iCOMMIT_VECTOR[commit_idx];

    always_comb begin
        state_nxt       = state;
        req_nxt         = req;
        flags_valid_nxt = flags_valid;
        flags_nxt       = flags;
        tag_nxt         = tag;
        case (state)
            FLAGREN_ST_FREE_WAIT: begin
                if (bus.iFREELIST_REGIST_VALID) begin
                    state_nxt = FLAGREN_ST_REG_WAIT;
                    req_nxt   = 1'b0;
                end else begin
                    req_nxt         = 1'b1;
                    flags_valid_nxt = 1'b0;
                end
            end
            FLAGREN_ST_REG_WAIT: begin
                if (reg_hit) begin
                    tag_nxt   = reg_tag;
                    state_nxt = FLAGREN_ST_FLAG_WAIT;
                end
            end
            FLAGREN_ST_FLAG_WAIT: begin
                if (cdb_hit) begin
                    flags_nxt       = cdb_flags;
                    flags_valid_nxt = 1'b1;
                    state_nxt       = FLAGREN_ST_COMMIT_WAIT;
                end
            end
            FLAGREN_ST_COMMIT_WAIT: begin
                if (commit_hit) begin
                    flags_valid_nxt = 1'b0;
                    state_nxt       = FLAGREN_ST_RELEASE;
                end
            end
            FLAGREN_ST_RELEASE: begin
                flags_nxt = '0;
                tag_nxt   = '0;
                state_nxt = FLAGREN_ST_FREE_WAIT;
            end
            default: state_nxt = FLAGREN_ST_RELEASE;
        endcase

        // An instruction already waiting for commit is past the flush point,
        // so the flush only reclaims entries that have not produced yet.
        if (bus.iREMOVE_VALID && (state != FLAGREN_ST_COMMIT_WAIT)) begin
            state_nxt       = FLAGREN_ST_FREE_WAIT;
            req_nxt         = 1'b0;
            flags_valid_nxt = 1'b0;
            flags_nxt       = '0;
            tag_nxt         = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state       <= FLAGREN_ST_FREE_WAIT;
            req         <= 1'b0;
            flags_valid <= 1'b0;
            flags       <= '0;
            tag         <= '0;
        end else begin
            state       <= state_nxt;
            req         <= req_nxt;
            flags_valid <= flags_valid_nxt;
            flags       <= flags_nxt;
            tag         <= tag_nxt;
        end
    end

    assign bus.oINFO_FREELIST_REQ = req;
    assign bus.oINFO_FLAGS_VALID  = flags_valid;
    assign bus.oINFO_FLAGS        = flags;
    assign bus.oINFO_COMMIT_TAG   = tag;
    assign bus.oINFO_STATE        = state;
    assign bus.oINFO_RELEASE      = (state == FLAGREN_ST_RELEASE);
endmodule
